pd_sched: RTL and testbench

PD_SCHED -- requirements
Module: pd_sched

---
 rtl/pd_sched_if.sv | 34 +++
 rtl/pd_sched.sv | 146 ++++++++++++++
 tb/tb_pd_sched.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pd_sched_if.sv
// pd_sched_if: bundles the sensor sample inputs, the link to the shared PD
// unit and the captured per-axis term outputs of pd_sched.
// The slave modport is the scheduler's view.
interface pd_sched_if;
    logic               vld;
    logic signed [15:0] ptch_des, roll_des, yaw_des;
    logic signed [15:0] ptch_act, roll_act, yaw_act;
    logic signed [9:0]  pterm;
    logic signed [11:0] dterm;
    logic signed [15:0] pd_desired, pd_actual;
    logic               pd_vld;
    logic signed [9:0]  ptch_pterm, roll_pterm, yaw_pterm;
    logic signed [11:0] ptch_dterm, roll_dterm, yaw_dterm;
    logic               terms_rdy, busy;
    logic [7:0]         ovrn_cnt;

    modport slave (
        input  vld, ptch_des, roll_des, yaw_des, ptch_act, roll_act, yaw_act,
        input  pterm, dterm,
        output pd_desired, pd_actual, pd_vld,
        output ptch_pterm, roll_pterm, yaw_pterm,
        output ptch_dterm, roll_dterm, yaw_dterm,
        output terms_rdy, busy, ovrn_cnt
    );

    modport master (
        output vld, ptch_des, roll_des, yaw_des, ptch_act, roll_act, yaw_act,
        output pterm, dterm,
        input  pd_desired, pd_actual, pd_vld,
        input  ptch_pterm, roll_pterm, yaw_pterm,
        input  ptch_dterm, roll_dterm, yaw_dterm,
        input  terms_rdy, busy, ovrn_cnt
    );
endinterface

// File: rtl/pd_sched.sv
// pd_sched: time-multiplexes one shared PD unit over the pitch, roll and yaw
// axes in a fixed order so the PD unit's derivative queue stays axis-aligned.
// Each axis slot lasts PD_LAT+1 cycles; pd_vld marks the last slot cycle, on
// whose edge the returned P/D terms are captured for that axis.
// Optional feature: define PD_SCHED_OVRN_CNT_EN to count (saturating) the vld
// strobes dropped while a sample set is in progress; otherwise ovrn_cnt is 0.
module pd_sched #(
    parameter int PD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    pd_sched_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SLOT, DONE} state_t;

    localparam logic [2:0] LAST_CNT = 3'(PD_LAT);

    state_t     state_q, state_d;
    logic [1:0] axis_q, axis_d;
    logic [2:0] cnt_q, cnt_d;
    logic       accept, slot_last;

    logic signed [15:0] ptch_des_q, roll_des_q, yaw_des_q;
    logic signed [15:0] ptch_act_q, roll_act_q, yaw_act_q;
    logic signed [15:0] pd_des_q, pd_act_q;
    logic signed [9:0]  ptch_p_q, roll_p_q, yaw_p_q;
    logic signed [11:0] ptch_d_q, roll_d_q, yaw_d_q;

    // Sequencer state, axis index and slot counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            axis_q  <= 2'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            axis_q  <= axis_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: start on vld when not busy, walk ptch/roll/yaw slots, then DONE.
    always_comb begin
        state_d   = state_q;
        axis_d    = axis_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        slot_last = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.vld) begin
                    accept  = 1'b1;
                    state_d = SLOT;
                    axis_d  = 2'd0;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SLOT: begin
                if (cnt_q == LAST_CNT) begin
                    slot_last = 1'b1;
                    cnt_d     = 3'd0;
                    if (axis_q == 2'd2) begin
                        state_d = DONE;
                        axis_d  = 2'd0;
                    end else begin
                        axis_d  = axis_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample latch, PD operand drive and per-axis term capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptch_des_q <= '0; roll_des_q <= '0; yaw_des_q <= '0;
            ptch_act_q <= '0; roll_act_q <= '0; yaw_act_q <= '0;
            pd_des_q   <= '0; pd_act_q   <= '0;
            ptch_p_q   <= '0; roll_p_q   <= '0; yaw_p_q   <= '0;
            ptch_d_q   <= '0; roll_d_q   <= '0; yaw_d_q   <= '0;
        end else begin
            if (accept) begin
                ptch_des_q <= bus.ptch_des; roll_des_q <= bus.roll_des; yaw_des_q <= bus.yaw_des;
                ptch_act_q <= bus.ptch_act; roll_act_q <= bus.roll_act; yaw_act_q <= bus.yaw_act;
                // The pitch slot starts on the next cycle, so drive its operands straight away.
                pd_des_q   <= bus.ptch_des;
                pd_act_q   <= bus.ptch_act;
            end
            if (slot_last) begin
                case (axis_q)
                    2'd0: begin
                        ptch_p_q <= bus.pterm;
                        ptch_d_q <= bus.dterm;
                        pd_des_q <= roll_des_q;
                        pd_act_q <= roll_act_q;
                    end
                    2'd1: begin
                        roll_p_q <= bus.pterm;
                        roll_d_q <= bus.dterm;
                        pd_des_q <= yaw_des_q;
                        pd_act_q <= yaw_act_q;
                    end
                    default: begin
                        // Yaw is the final slot; operands keep the yaw sample while idle.
                        yaw_p_q <= bus.pterm;
                        yaw_d_q <= bus.dterm;
                    end
                endcase
            end
        end
    end

`ifdef PD_SCHED_OVRN_CNT_EN
    logic [7:0] ovrn_q;

    // Saturating count of vld strobes dropped while a sample set is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovrn_q <= 8'd0;
        end else if (bus.vld && (state_q == SLOT) && (ovrn_q != 8'hFF)) begin
            ovrn_q <= ovrn_q + 8'd1;
        end
    end

    assign bus.ovrn_cnt = ovrn_q;
`else
    assign bus.ovrn_cnt = 8'd0;
`endif

    assign bus.pd_desired = pd_des_q;
    assign bus.pd_actual  = pd_act_q;
    assign bus.pd_vld     = (state_q == SLOT) && (cnt_q == LAST_CNT);
    assign bus.busy       = (state_q == SLOT);
    assign bus.terms_rdy  = (state_q == DONE);
    assign bus.ptch_pterm = ptch_p_q;
    assign bus.roll_pterm = roll_p_q;
    assign bus.yaw_pterm  = yaw_p_q;
    assign bus.ptch_dterm = ptch_d_q;
    assign bus.roll_dterm = roll_d_q;
    assign bus.yaw_dterm  = yaw_d_q;
endmodule

// File: tb/tb_pd_sched.sv
// tb_pd_sched: scoreboard bench for pd_sched. Three instances (PD_LAT 2, 1, 4)
// each drive a PD stub that echoes pterm=pd_actual[9:0],
// dterm={2'b0,pd_desired[9:0]} after PD_LAT register stages.
module tb_pd_sched;
    logic clk = 1'b0;
    logic rst;
    logic var_en;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef PD_SCHED_OVRN_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] pd, pa, rd, ra, yd, ya;
        logic [9:0]  pp, rp, yp;
        logic [11:0] dp, dr, dy;
    } vec_t;
    typedef struct { int cyc; logic [15:0] des, act; } pv_t;
    typedef struct { int cyc; logic [9:0] pp, rp, yp; logic [11:0] dp, dr, dy; } tr_t;

    pv_t pvq [3][$];
    tr_t trq [3][$];

    pd_sched_if b2 ();
    pd_sched_if b1 ();
    pd_sched_if b4 ();

    pd_sched #(.PD_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    pd_sched #(.PD_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    pd_sched #(.PD_LAT(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));

    assign b1.vld = b2.vld & var_en;
    assign b4.vld = b2.vld & var_en;
    assign b1.ptch_des = b2.ptch_des; assign b4.ptch_des = b2.ptch_des;
    assign b1.roll_des = b2.roll_des; assign b4.roll_des = b2.roll_des;
    assign b1.yaw_des  = b2.yaw_des;  assign b4.yaw_des  = b2.yaw_des;
    assign b1.ptch_act = b2.ptch_act; assign b4.ptch_act = b2.ptch_act;
    assign b1.roll_act = b2.roll_act; assign b4.roll_act = b2.roll_act;
    assign b1.yaw_act  = b2.yaw_act;  assign b4.yaw_act  = b2.yaw_act;

    // PD unit stubs with PD_LAT cycles of latency.
    logic [15:0] s2d [2], s2a [2], s1d [1], s1a [1], s4d [4], s4a [4];
    always @(posedge clk) begin
        s2d[0] <= b2.pd_desired; s2a[0] <= b2.pd_actual;
        s2d[1] <= s2d[0];        s2a[1] <= s2a[0];
        s1d[0] <= b1.pd_desired; s1a[0] <= b1.pd_actual;
        s4d[0] <= b4.pd_desired; s4a[0] <= b4.pd_actual;
        for (int i = 1; i < 4; i++) begin
            s4d[i] <= s4d[i-1];
            s4a[i] <= s4a[i-1];
        end
    end
    assign b2.pterm = s2a[1][9:0]; assign b2.dterm = {2'b00, s2d[1][9:0]};
    assign b1.pterm = s1a[0][9:0]; assign b1.dterm = {2'b00, s1d[0][9:0]};
    assign b4.pterm = s4a[3][9:0]; assign b4.dterm = {2'b00, s4d[3][9:0]};

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, a, e, cyc);
        else n_pass++;
    endtask

    task automatic expect_set(input int k, input int t0, input int lat, input vec_t v, input int npv);
        pv_t p;
        tr_t t;
        for (int i = 0; i < npv; i++) begin
            p.cyc = t0 + (lat + 1) * (i + 1);
            p.des = (i == 0) ? v.pd : (i == 1) ? v.rd : v.yd;
            p.act = (i == 0) ? v.pa : (i == 1) ? v.ra : v.ya;
            pvq[k].push_back(p);
        end
        if (npv == 3) begin
            t.cyc = t0 + 3 * (lat + 1) + 1;
            t.pp = v.pp; t.rp = v.rp; t.yp = v.yp;
            t.dp = v.dp; t.dr = v.dr; t.dy = v.dy;
            trq[k].push_back(t);
        end
    endtask

    task automatic mon(input int k, input logic pv, input logic [15:0] des, input logic [15:0] act,
                       input logic tr, input logic [9:0] pp, input logic [9:0] rp, input logic [9:0] yp,
                       input logic [11:0] dp, input logic [11:0] dr, input logic [11:0] dy);
        pv_t e;
        tr_t t;
        if (pv === 1'b1) begin
            if (pvq[k].size() == 0) begin
                n_chk++;
                $display("FAIL u%0d_pd_vld: got unexpected pulse at cycle %0d, required none", k, cyc);
            end else begin
                e = pvq[k].pop_front();
                chk($sformatf("u%0d_pd_vld_cycle", k), cyc, e.cyc);
                chk($sformatf("u%0d_pd_desired", k), {16'd0, des}, {16'd0, e.des});
                chk($sformatf("u%0d_pd_actual", k), {16'd0, act}, {16'd0, e.act});
            end
        end
        if (tr === 1'b1) begin
            if (trq[k].size() == 0) begin
                n_chk++;
                $display("FAIL u%0d_terms_rdy: got unexpected pulse at cycle %0d, required none", k, cyc);
            end else begin
                t = trq[k].pop_front();
                chk($sformatf("u%0d_terms_rdy_cycle", k), cyc, t.cyc);
                chk($sformatf("u%0d_ptch_pterm", k), {22'd0, pp}, {22'd0, t.pp});
                chk($sformatf("u%0d_roll_pterm", k), {22'd0, rp}, {22'd0, t.rp});
                chk($sformatf("u%0d_yaw_pterm", k), {22'd0, yp}, {22'd0, t.yp});
                chk($sformatf("u%0d_ptch_dterm", k), {20'd0, dp}, {20'd0, t.dp});
                chk($sformatf("u%0d_roll_dterm", k), {20'd0, dr}, {20'd0, t.dr});
                chk($sformatf("u%0d_yaw_dterm", k), {20'd0, dy}, {20'd0, t.dy});
            end
        end
    endtask

    // Output monitor: pops the scoreboard whenever a DUT presents pd_vld or terms_rdy.
    always @(negedge clk) begin
        if (cyc > 1) begin
            mon(0, b2.pd_vld, b2.pd_desired, b2.pd_actual, b2.terms_rdy, b2.ptch_pterm, b2.roll_pterm,
                b2.yaw_pterm, b2.ptch_dterm, b2.roll_dterm, b2.yaw_dterm);
            mon(1, b1.pd_vld, b1.pd_desired, b1.pd_actual, b1.terms_rdy, b1.ptch_pterm, b1.roll_pterm,
                b1.yaw_pterm, b1.ptch_dterm, b1.roll_dterm, b1.yaw_dterm);
            mon(2, b4.pd_vld, b4.pd_desired, b4.pd_actual, b4.terms_rdy, b4.ptch_pterm, b4.roll_pterm,
                b4.yaw_pterm, b4.ptch_dterm, b4.roll_dterm, b4.yaw_dterm);
        end
    end

    task automatic drive(input logic v, input vec_t s);
        b2.vld = v;
        b2.ptch_des = s.pd; b2.ptch_act = s.pa;
        b2.roll_des = s.rd; b2.roll_act = s.ra;
        b2.yaw_des  = s.yd; b2.yaw_act  = s.ya;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vA, vB, vF;
        int t0;
        vA = '{16'h0010, 16'h0011, 16'h0020, 16'h0021, 16'h0030, 16'h0031,
               10'h011, 10'h021, 10'h031, 12'h010, 12'h020, 12'h030};
        vB = '{16'h1234, 16'h8ABC, 16'hFC05, 16'h7F3E, 16'h03FF, 16'hFFFF,
               10'h2BC, 10'h33E, 10'h3FF, 12'h234, 12'h005, 12'h3FF};
        vF = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
               10'h000, 10'h000, 10'h000, 12'h000, 12'h000, 12'h000};

        // Reset state.
        rst = 1'b1; var_en = 1'b0;
        drive(1'b0, vF);
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, b2.busy}, 0);
        chk("rst_pd_vld", {31'd0, b2.pd_vld}, 0);
        chk("rst_terms_rdy", {31'd0, b2.terms_rdy}, 0);
        chk("rst_pd_desired", {16'd0, b2.pd_desired}, 0);
        chk("rst_pd_actual", {16'd0, b2.pd_actual}, 0);
        chk("rst_ptch_pterm", {22'd0, b2.ptch_pterm}, 0);
        chk("rst_yaw_dterm", {20'd0, b2.yaw_dterm}, 0);
        chk("rst_ovrn_cnt", {24'd0, b2.ovrn_cnt}, 0);
        chk("rst_u1_busy", {31'd0, b1.busy}, 0);
        chk("rst_u4_busy", {31'd0, b4.busy}, 0);
        step();

        // Basic set on all three latencies; inputs scrambled right after vld.
        t0 = cyc; var_en = 1'b1;
        drive(1'b1, vA);
        expect_set(0, t0, 2, vA, 3);
        expect_set(1, t0, 1, vA, 3);
        expect_set(2, t0, 4, vA, 3);
        step();
        var_en = 1'b0;
        drive(1'b0, vF);
        @(negedge clk);
        chk("a_busy_c1", {31'd0, b2.busy}, 1);
        chk("a_pd_desired_held_c1", {16'd0, b2.pd_desired}, 32'h0010);
        chk("a_pd_actual_held_c1", {16'd0, b2.pd_actual}, 32'h0011);
        while (cyc < t0 + 10) step();
        @(negedge clk);
        chk("a_done_busy", {31'd0, b2.busy}, 0);
        chk("a_done_terms_rdy", {31'd0, b2.terms_rdy}, 1);
        while (cyc < t0 + 18) step();

        // Overrun: extra vld strobes at cycles 4 and 7 must be dropped.
        t0 = cyc;
        drive(1'b1, vB);
        expect_set(0, t0, 2, vB, 3);
        for (int i = 1; i <= 11; i++) begin
            step();
            drive((i == 4) || (i == 7), vF);
        end
        @(negedge clk);
        chk("ovr_cnt_after_2_drops", {24'd0, b2.ovrn_cnt}, OVR_EN ? 32'd2 : 32'd0);
        step(); step();

        // Reset mid-sequence at cycle 5 with a coincident vld.
        t0 = cyc;
        drive(1'b1, vA);
        expect_set(0, t0, 2, vA, 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 5) begin
                rst = 1'b1;
                drive(1'b1, vB);
            end else begin
                drive(1'b0, vA);
            end
        end
        step();
        rst = 1'b0;
        drive(1'b0, vF);
        @(negedge clk);
        chk("abort_busy", {31'd0, b2.busy}, 0);
        chk("abort_ptch_pterm", {22'd0, b2.ptch_pterm}, 0);
        chk("abort_roll_dterm", {20'd0, b2.roll_dterm}, 0);
        chk("abort_yaw_pterm", {22'd0, b2.yaw_pterm}, 0);
        chk("abort_pd_desired", {16'd0, b2.pd_desired}, 0);
        chk("abort_ovrn_cnt", {24'd0, b2.ovrn_cnt}, 0);
        while (cyc < t0 + 14) step();

        // vld held high: DONE-cycle acceptance back to back, 306 drops saturate ovrn_cnt.
        t0 = cyc;
        for (int k = 0; k < 34; k++) expect_set(0, t0 + 10 * k, 2, vA, 3);
        drive(1'b1, vA);
        while (cyc < t0 + 340) begin
            step();
            if (cyc == t0 + 340) drive(1'b0, vF);
            if (cyc == t0 + 11) begin
                @(negedge clk);
                chk("done_vld_busy_c11", {31'd0, b2.busy}, 1);
            end
        end
        @(negedge clk);
        chk("ovrn_cnt_saturated", {24'd0, b2.ovrn_cnt}, OVR_EN ? 32'hFF : 32'd0);
        while (cyc < t0 + 346) step();

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d_pd_vld_left", k), pvq[k].size(), 0);
            chk($sformatf("u%0d_terms_rdy_left", k), trq[k].size(), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
